// File: rtl/qspi_arb_pkg.sv
// Shared types and default sizing for the QSPI read-engine arbiter.
// No logic; pure declarations.
// No flow control.
package qspi_arb_pkg;

  localparam int AW_DEF      = 24;
  localparam int LW_DEF      = 8;
  localparam int TGAP_DEF    = 3;
  localparam int TIMEOUT_DEF = 4095;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2,
    GAP   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

endpackage

// File: rtl/qspi_rr2.sv
// Two-way round-robin picker: a tie goes to the port not served last.
// Purely combinational, zero latency.
// No flow control; caller samples valid/owner when it can accept a grant.
module qspi_rr2 import qspi_arb_pkg::*; (
  input  logic   a_req,
  input  logic   b_req,
  input  owner_t last_owner,
  output logic   valid,
  output owner_t owner
);

  always_comb begin
    valid = a_req | b_req;
    owner = OWN_A;
    if (a_req && b_req) begin
      owner = (last_owner == OWN_A) ? OWN_B : OWN_A;
    end else if (b_req) begin
      owner = OWN_B;
    end
  end

endmodule

// File: rtl/qspi_arb.sv
// Arbitrates two burst readers onto one QSPI read engine with CS# gap and watchdog.
// Grant 1 cycle after req; bytes and done are registered, 1 cycle after the engine.
// Requests are level-held; GAP/XFER simply defer them, nothing is dropped.
module qspi_arb import qspi_arb_pkg::*; #(
  parameter int AW      = AW_DEF,
  parameter int LW      = LW_DEF,
  parameter int TGAP    = TGAP_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          spiclk,
  input  logic          rstn,
  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  input  logic [LW-1:0] a_len,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  input  logic [LW-1:0] b_len,
  output logic          a_gnt,
  output logic          b_gnt,
  output logic          a_rvalid,
  output logic          b_rvalid,
  output logic [7:0]    rdata,
  output logic          a_done,
  output logic          b_done,
  output logic          err,
  output logic          eng_start,
  output logic [AW-1:0] eng_addr,
  output logic [LW-1:0] eng_len,
  output logic          eng_abort,
  input  logic          eng_rvalid,
  input  logic [7:0]    eng_rdata,
  input  logic          eng_done
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam int GW  = $clog2(TGAP + 2);
  localparam logic [WDW-1:0] WD_HIT = WDW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  owner_t        owner_q, last_q, pick_owner;
  logic          pick_vld;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] len_q;
  logic [LW:0]   cnt_q, cnt_tot, len_exp;
  logic [WDW-1:0] wd_q;
  logic [GW-1:0] gap_q;
  logic          a_rv_q, b_rv_q, a_done_q, b_done_q, err_q, abort_q;
  logic [7:0]    rdata_q;
  logic          in_xfer, wd_hit, xfer_end, cnt_bad;

  qspi_rr2 u_rr (
    .a_req      (a_req),
    .b_req      (b_req),
    .last_owner (last_q),
    .valid      (pick_vld),
    .owner      (pick_owner)
  );

  assign in_xfer = (state_q == XFER);
  assign wd_hit  = (wd_q == WD_HIT);
  // A byte arriving in the same cycle as eng_done still counts toward the total.
  assign cnt_tot = cnt_q + (LW+1)'(eng_rvalid);
  assign len_exp = (LW+1)'(len_q) + (LW+1)'(1);
  assign cnt_bad = (cnt_tot != len_exp);

  always_comb begin
    state_d  = state_q;
    xfer_end = 1'b0;
    case (state_q)
      IDLE:    if (pick_vld) state_d = START;
      START:   state_d = XFER;
      XFER: begin
        if (eng_done || wd_hit) begin
          state_d  = GAP;
          xfer_end = 1'b1;
        end
      end
      GAP:     if (gap_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge spiclk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge spiclk or negedge rstn) begin
    if (!rstn) begin
      owner_q  <= OWN_A;
      last_q   <= OWN_B;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      wd_q     <= '0;
      gap_q    <= '0;
      a_rv_q   <= 1'b0;
      b_rv_q   <= 1'b0;
      rdata_q  <= '0;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && pick_vld) begin
        owner_q <= pick_owner;
        last_q  <= pick_owner;
        addr_q  <= (pick_owner == OWN_A) ? a_addr : b_addr;
        len_q   <= (pick_owner == OWN_A) ? a_len : b_len;
      end
      // Watchdog holds cycles elapsed since eng_start, so the eng_start cycle is 0.
      if (state_q == START) begin
        cnt_q <= '0;
        wd_q  <= WDW'(1);
      end
      if (in_xfer) begin
        if (eng_rvalid) cnt_q <= cnt_tot;
        if (wd_q != '1) wd_q <= wd_q + WDW'(1);
      end
      a_rv_q <= in_xfer && eng_rvalid && (owner_q == OWN_A);
      b_rv_q <= in_xfer && eng_rvalid && (owner_q == OWN_B);
      if (in_xfer && eng_rvalid) rdata_q <= eng_rdata;
      a_done_q <= xfer_end && (owner_q == OWN_A);
      b_done_q <= xfer_end && (owner_q == OWN_B);
      err_q    <= xfer_end && (eng_done ? cnt_bad : 1'b1);
      abort_q  <= xfer_end && !eng_done;
      if (xfer_end)                         gap_q <= GW'(TGAP);
      else if (state_q == GAP && gap_q != '0) gap_q <= gap_q - GW'(1);
    end
  end

  assign eng_start = (state_q == START);
  assign a_gnt     = eng_start && (owner_q == OWN_A);
  assign b_gnt     = eng_start && (owner_q == OWN_B);
  assign eng_addr  = addr_q;
  assign eng_len   = len_q;
  assign a_rvalid  = a_rv_q;
  assign b_rvalid  = b_rv_q;
  assign rdata     = rdata_q;
  assign a_done    = a_done_q;
  assign b_done    = b_done_q;
  assign err       = err_q;
  assign eng_abort = abort_q;

endmodule

// File: tb/tb_qspi_arb.sv
// Directed bench for qspi_arb with a short watchdog (TIMEOUT=64) and TGAP=3.
module tb_qspi_arb;

  localparam int AW = 24;
  localparam int LW = 8;
  localparam int TGAP = 3;
  localparam int TIMEOUT = 64;

  logic          spiclk = 1'b0;
  logic          rstn = 1'b1;
  logic          a_req, b_req;
  logic [AW-1:0] a_addr, b_addr;
  logic [LW-1:0] a_len, b_len;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid, a_done, b_done, err;
  logic [7:0]    rdata;
  logic          eng_start, eng_abort;
  logic [AW-1:0] eng_addr;
  logic [LW-1:0] eng_len;
  logic          eng_rvalid, eng_done;
  logic [7:0]    eng_rdata;

  int errors = 0;
  int checks = 0;

  qspi_arb #(.AW(AW), .LW(LW), .TGAP(TGAP), .TIMEOUT(TIMEOUT)) dut (
    .spiclk(spiclk), .rstn(rstn),
    .a_req(a_req), .a_addr(a_addr), .a_len(a_len),
    .b_req(b_req), .b_addr(b_addr), .b_len(b_len),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .rdata(rdata), .a_done(a_done), .b_done(b_done), .err(err),
    .eng_start(eng_start), .eng_addr(eng_addr), .eng_len(eng_len), .eng_abort(eng_abort),
    .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata), .eng_done(eng_done)
  );

  always #5 spiclk = ~spiclk;

  task automatic tick();
    @(posedge spiclk);
    #1;
  endtask

  task automatic clear_inputs();
    a_req = 0; b_req = 0; a_addr = '0; b_addr = '0; a_len = '0; b_len = '0;
    eng_rvalid = 0; eng_rdata = '0; eng_done = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rstn = 0;
    tick(); tick();
    rstn = 1;
  endtask

  task automatic wait_gnt(input int limit, output int n);
    n = 0;
    while (!eng_start && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic send_bytes(input int nb);
    for (int i = 0; i < nb; i++) begin
      eng_rvalid = 1;
      eng_rdata  = 8'(8'hA0 + i);
      tick();
    end
    eng_rvalid = 0;
  endtask

  task automatic finish_burst();
    eng_done = 1;
    tick();
    eng_done = 0;
  endtask

  task automatic test_reset();
    logic [8:0] flags;
    clear_inputs();
    #2 rstn = 0;
    #1;
    flags = {a_gnt, b_gnt, a_rvalid, b_rvalid, a_done, b_done, err, eng_start, eng_abort};
    checks++;
    if (flags !== 9'd0 || rdata !== 8'd0 || eng_addr !== '0 || eng_len !== '0) begin
      errors++;
      $display("FAIL reset_outputs: flags=%b rdata=%h addr=%h len=%h, want all zero",
               flags, rdata, eng_addr, eng_len);
    end
    tick(); tick();
    rstn = 1;
    tick();
  endtask

  task automatic test_single_a();
    logic [7:0] exp_b;
    a_req = 1; a_addr = 24'h000100; a_len = 8'd3;
    tick();
    checks++;
    if (a_gnt !== 1 || b_gnt !== 0 || eng_start !== 1 || eng_addr !== 24'h000100 || eng_len !== 8'd3) begin
      errors++;
      $display("FAIL single_grant: a_gnt=%b b_gnt=%b start=%b addr=%h len=%h, want 1 0 1 000100 03",
               a_gnt, b_gnt, eng_start, eng_addr, eng_len);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      exp_b = 8'(8'h11 * (i + 1));
      eng_rvalid = 1; eng_rdata = exp_b;
      tick();
      checks++;
      if (a_rvalid !== 1 || b_rvalid !== 0 || rdata !== exp_b) begin
        errors++;
        $display("FAIL single_byte%0d: a_rv=%b b_rv=%b rdata=%h, want 1 0 %h",
                 i, a_rvalid, b_rvalid, rdata, exp_b);
      end
    end
    eng_rvalid = 0;
    finish_burst();
    a_req = 0;
    checks++;
    if (a_done !== 1 || b_done !== 0 || err !== 0 || eng_abort !== 0) begin
      errors++;
      $display("FAIL single_done: a_done=%b b_done=%b err=%b abort=%b, want 1 0 0 0",
               a_done, b_done, err, eng_abort);
    end
    repeat (6) tick();
  endtask

  task automatic test_round_robin();
    int n;
    do_reset();
    a_req = 1; a_addr = 24'h000300; a_len = 8'd0;
    b_req = 1; b_addr = 24'h000200; b_len = 8'd0;
    tick();
    checks++;
    if (a_gnt !== 1 || b_gnt !== 0 || eng_addr !== 24'h000300) begin
      errors++;
      $display("FAIL rr_first: a_gnt=%b b_gnt=%b addr=%h, want 1 0 000300", a_gnt, b_gnt, eng_addr);
    end
    tick();
    send_bytes(1);
    finish_burst();
    wait_gnt(20, n);
    checks++;
    if (n != TGAP + 2 || b_gnt !== 1 || a_gnt !== 0 || eng_addr !== 24'h000200) begin
      errors++;
      $display("FAIL rr_second: cycles=%0d b_gnt=%b a_gnt=%b addr=%h, want %0d 1 0 000200",
               n, b_gnt, a_gnt, eng_addr, TGAP + 2);
    end
    tick();
    send_bytes(1);
    finish_burst();
    checks++;
    if (b_done !== 1 || a_done !== 0 || err !== 0) begin
      errors++;
      $display("FAIL rr_b_done: b_done=%b a_done=%b err=%b, want 1 0 0", b_done, a_done, err);
    end
    wait_gnt(20, n);
    checks++;
    if (a_gnt !== 1 || b_gnt !== 0) begin
      errors++;
      $display("FAIL rr_third: a_gnt=%b b_gnt=%b, want 1 0", a_gnt, b_gnt);
    end
    a_req = 0; b_req = 0;
    tick();
    send_bytes(1);
    finish_burst();
    repeat (6) tick();
  endtask

  task automatic test_short_burst();
    int n;
    a_req = 1; a_addr = 24'h004000; a_len = 8'd7;
    wait_gnt(10, n);
    a_req = 0;
    tick();
    send_bytes(6);
    finish_burst();
    checks++;
    if (a_done !== 1 || err !== 1 || eng_abort !== 0) begin
      errors++;
      $display("FAIL short_err: a_done=%b err=%b abort=%b, want 1 1 0", a_done, err, eng_abort);
    end
    repeat (6) tick();
  endtask

  task automatic test_timeout();
    int n;
    a_req = 1; a_addr = 24'h00ABCD; a_len = 8'd0;
    wait_gnt(10, n);
    n = 0;
    while (!a_done && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != TIMEOUT || eng_abort !== 1 || err !== 1) begin
      errors++;
      $display("FAIL timeout_abort: cycles=%0d abort=%b err=%b, want %0d 1 1", n, eng_abort, err, TIMEOUT);
    end
    wait_gnt(20, n);
    checks++;
    if (n != TGAP + 2 || a_gnt !== 1) begin
      errors++;
      $display("FAIL timeout_regrant: cycles=%0d a_gnt=%b, want %0d 1", n, a_gnt, TGAP + 2);
    end
    a_req = 0;
    tick();
    send_bytes(1);
    finish_burst();
    checks++;
    if (a_done !== 1 || err !== 0 || eng_abort !== 0) begin
      errors++;
      $display("FAIL timeout_recover: a_done=%b err=%b abort=%b, want 1 0 0", a_done, err, eng_abort);
    end
    repeat (6) tick();
  endtask

  task automatic test_gap();
    int n;
    int strays;
    a_req = 1; a_addr = 24'h000010; a_len = 8'd0;
    wait_gnt(10, n);
    tick();
    send_bytes(1);
    finish_burst();
    eng_rvalid = 1; eng_rdata = 8'hEE; eng_done = 1;
    strays = 0;
    n = 0;
    while (!eng_start && n < 20) begin
      tick();
      n++;
      if (a_rvalid || b_rvalid || a_done || b_done) strays++;
    end
    eng_rvalid = 0; eng_done = 0;
    checks++;
    if (n != TGAP + 2) begin
      errors++;
      $display("FAIL gap_len: next start after %0d cycles, want %0d", n, TGAP + 2);
    end
    checks++;
    if (strays != 0) begin
      errors++;
      $display("FAIL gap_stray: %0d stray strobes/dones, want 0", strays);
    end
    a_req = 0;
    tick();
    send_bytes(1);
    finish_burst();
    repeat (6) tick();
  endtask

  task automatic test_reset_mid();
    int n;
    int dones;
    logic [8:0] flags;
    b_req = 1; b_addr = 24'h000555; b_len = 8'd3;
    wait_gnt(10, n);
    tick();
    eng_rvalid = 1; eng_rdata = 8'h5A;
    tick();
    checks++;
    if (b_rvalid !== 1 || rdata !== 8'h5A) begin
      errors++;
      $display("FAIL midrst_pre: b_rv=%b rdata=%h, want 1 5a", b_rvalid, rdata);
    end
    rstn = 0;
    #1;
    flags = {a_gnt, b_gnt, a_rvalid, b_rvalid, a_done, b_done, err, eng_start, eng_abort};
    checks++;
    if (flags !== 9'd0 || rdata !== 8'd0 || eng_addr !== '0 || eng_len !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: flags=%b rdata=%h addr=%h len=%h, want all zero",
               flags, rdata, eng_addr, eng_len);
    end
    eng_done = 1;
    dones = 0;
    repeat (3) begin
      tick();
      if (a_done || b_done) dones++;
    end
    eng_rvalid = 0; eng_done = 0;
    rstn = 1;
    tick();
    checks++;
    if (dones != 0 || b_gnt !== 1 || a_gnt !== 0 || eng_addr !== 24'h000555) begin
      errors++;
      $display("FAIL midrst_regrant: dones=%0d b_gnt=%b a_gnt=%b addr=%h, want 0 1 0 000555",
               dones, b_gnt, a_gnt, eng_addr);
    end
    b_req = 0;
    tick();
    send_bytes(4);
    finish_burst();
    checks++;
    if (b_done !== 1 || err !== 0) begin
      errors++;
      $display("FAIL midrst_done: b_done=%b err=%b, want 1 0", b_done, err);
    end
    repeat (6) tick();
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_round_robin();
    test_short_burst();
    test_timeout();
    test_gap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
